// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the floating-point normalise/round pipeline.
//   FP_EXP_W / FP_MAN_W : default exponent and stored-fraction widths (binary32)
//   FLAG_*              : bit positions of the flag nibble {overflow, underflow, inexact, zero}
//   fp_flags_t          : packed view of the same nibble
//   fp_rmode_t          : rounding modes; the pipeline implements RM_RNE only
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_INEXACT   = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 3;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } fp_flags_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } fp_rmode_t;

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc -- combinational leading-zero counter.
//   in_bits : W-bit vector, MSB first
//   count   : number of zeros above the highest set bit (W when in_bits == 0)
module fp_lzc
    import fp_pkg::*;
#(
    parameter  int W  = 27,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  in_bits,
    output logic [CW-1:0] count
);

    // Ascending scan: the highest set bit is the last to write count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (in_bits[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe -- two-stage valid/ready pipeline that normalises an
// unnormalised magnitude (stage 1) and rounds to nearest-even and packs it
// into {sign, exp, fraction} (stage 2).
//
// Handshake: a beat moves across an interface on a rising clk edge where the
// producer's valid and the consumer's ready are both high. A stage loads when
// it is empty or its current beat leaves the same cycle; in_ready is
// combinational from out_ready, and out_result/out_flags hold while stalled.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_sign, in_exp       sign and biased exponent before normalisation
//   in_mant               {carry, hidden, fraction, guard, round, sticky}
//   out_valid/out_ready   output handshake
//   out_result            {sign, exp, fraction}
//   out_flags             {overflow, underflow, inexact, zero}
//
// Build option: define FP_NORM_SUBNORMAL_EN to produce subnormal results;
// otherwise tiny results flush to signed zero.
module fp_norm_round_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = FP_EXP_W,
    parameter  int MAN_W = FP_MAN_W,
    localparam int IN_W  = MAN_W + 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [IN_W-1:0]        in_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [3:0]             out_flags
);

    localparam int NW = IN_W - 1;          // normalised width: hidden..sticky
    localparam int EW = EXP_W + 2;         // signed internal exponent width
    localparam int CW = $clog2(NW + 1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

    // ---------------- handshake ----------------
    logic s1_valid, s2_valid, s1_advance, s1_load;

    assign s1_advance = s1_valid & (!s2_valid | out_ready);
    assign in_ready   = !s1_valid | s1_advance;
    assign s1_load    = in_valid & in_ready;
    assign out_valid  = s2_valid;

    // ---------------- stage 1: normalise ----------------
    logic [CW-1:0]          lz, shamt;
    logic signed [EW-1:0]   in_exp_s, n_exp;
    logic [NW-1:0]          n_mant;

    fp_lzc #(.W(NW)) u_lzc (
        .in_bits (in_mant[NW-1:0]),
        .count   (lz)
    );

    always_comb begin
        in_exp_s = $signed({2'b00, in_exp});
        shamt    = lz;
        n_mant   = in_mant[NW-1:0];
        n_exp    = in_exp_s;
        if (in_mant[IN_W-1]) begin
            // Carry set: one place right, the dropped bit folds into sticky.
            n_mant = {in_mant[IN_W-1:2], |in_mant[1:0]};
            n_exp  = in_exp_s + EXP_ONE;
        end else begin
`ifdef FP_NORM_SUBNORMAL_EN
            // Stop the left shift once the exponent reaches 1.
            if (in_exp == '0) begin
                shamt = '0;
            end else if (in_exp_s - EXP_ONE < $signed({{(EW-CW){1'b0}}, lz})) begin
                shamt = CW'(in_exp_s - EXP_ONE);
            end
`endif
            n_mant = in_mant[NW-1:0] << shamt;
            n_exp  = in_exp_s - $signed({{(EW-CW){1'b0}}, shamt});
`ifdef FP_NORM_SUBNORMAL_EN
            // With the shift limited, only a zero input exponent sits below 1;
            // one right step re-expresses it at exponent 1 (subnormal scale).
            if (in_exp == '0) begin
                n_mant = {1'b0, n_mant[NW-1:2], |n_mant[1:0]};
                n_exp  = EXP_ONE;
            end
`endif
        end
    end

    logic                 s1_sign, s1_zero;
    logic signed [EW-1:0] s1_exp;
    logic [NW-1:0]        s1_mant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_sign <= in_sign;
                s1_zero <= (in_mant == '0);
                s1_exp  <= n_exp;
                s1_mant <= n_mant;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic                  inc, inexact;
    logic [MAN_W+1:0]      rnd;          // {carry, hidden, fraction}
    logic signed [EW-1:0]  r_exp;
    logic [MAN_W-1:0]      r_frac;
    logic [EXP_W+MAN_W:0]  r_result;
    fp_flags_t             r_flags;

    always_comb begin
        inexact = |s1_mant[2:0];
        inc     = s1_mant[2] & (s1_mant[1] | s1_mant[0] | s1_mant[3]);
        rnd     = {1'b0, s1_mant[NW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        r_frac  = rnd[MAN_W-1:0];
        r_exp   = s1_exp;
        if (rnd[MAN_W+1]) begin
            r_frac = '0;
            r_exp  = s1_exp + EXP_ONE;
        end else if (!rnd[MAN_W]) begin
            // No hidden bit: subnormal or zero magnitude, exponent field 0.
            r_exp = '0;
        end

        r_result        = {s1_sign, r_exp[EXP_W-1:0], r_frac};
        r_flags         = '0;
        r_flags.inexact = inexact;

        if (s1_zero) begin
            r_result     = '0;
            r_flags      = '0;
            r_flags.zero = 1'b1;
        end else if (r_exp >= EXP_INF) begin
            r_result          = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_flags.overflow  = 1'b1;
            r_flags.inexact   = 1'b1;
        end
`ifdef FP_NORM_SUBNORMAL_EN
        else begin
            r_flags.underflow = inexact & (r_exp == '0);
            r_flags.zero      = (r_exp == '0) && (r_frac == '0);
        end
`else
        else if (r_exp < EXP_ONE) begin
            r_result          = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
            r_flags.underflow = 1'b1;
            r_flags.inexact   = 1'b1;
            r_flags.zero      = 1'b1;
        end
`endif
    end

    fp_flags_t s2_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            s2_flags   <= '0;
        end else begin
            if (!s2_valid | out_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_advance) begin
                out_result <= r_result;
                s2_flags   <= r_flags;
            end
        end
    end

    assign out_flags = s2_flags;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe -- directed bench for fp_norm_round_pipe (EXP_W=8, MAN_W=23).
// Expected results are hand-computed binary32 encodings; flags are {ovf, unf, inx, zero}.
`timescale 1ns/1ps
module tb_fp_norm_round_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  flag_q[$];

    fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // {carry, hidden, fraction, guard, round, sticky}
    function automatic logic [27:0] mk(input logic carry, input logic hidden,
                                       input logic [22:0] frac, input logic [2:0] grs);
        return {carry, hidden, frac, grs};
    endfunction

    // ---------------- driver ----------------
    // Presents one beat with out_ready high and returns the emerging result and
    // the number of cycles between acceptance and out_valid.
    task automatic drive_one(input logic sg, input logic [7:0] e, input logic [27:0] m,
                             output logic [31:0] res, output logic [3:0] fl, output int lat);
        int wait_cyc;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = sg;
        in_exp    = e;
        in_mant   = m;
        wait_cyc  = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
        fl  = out_flags;
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout: out_valid never rose, waited %0d cycles", lat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_result !== 32'h0) begin
            failures++; $display("FAIL reset_out_result: got %h want 00000000", out_result);
        end
        checks++;
        if (out_flags !== 4'b0000) begin
            failures++; $display("FAIL reset_out_flags: got %b want 0000", out_flags);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        logic [31:0] res; logic [3:0] fl; int lat;
        drive_one(1'b0, 8'd127, mk(1'b0, 1'b1, 23'h0, 3'b000), res, fl, lat);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL latency_cycles: got %0d want 2", lat);
        end
        checks++;
        if (res !== 32'h3F800000 || fl !== 4'b0000) begin
            failures++; $display("FAIL latency_one: got %h/%b want 3f800000/0000", res, fl);
        end
    endtask

    task automatic test_normalise();
        logic [7:0]  e[4];
        logic        s[4];
        logic [27:0] m[4];
        logic [31:0] er[4];
        logic [31:0] res; logic [3:0] fl; int lat;
        // carry set, one leading zero, signed one, four leading zeros
        e[0] = 8'd127; s[0] = 1'b0; m[0] = mk(1'b1, 1'b0, 23'h0, 3'b000);  er[0] = 32'h40000000;
        e[1] = 8'd127; s[1] = 1'b0; m[1] = 28'h1 << 25;                    er[1] = 32'h3F000000;
        e[2] = 8'd127; s[2] = 1'b1; m[2] = mk(1'b0, 1'b1, 23'h0, 3'b000);  er[2] = 32'hBF800000;
        e[3] = 8'd130; s[3] = 1'b0; m[3] = 28'h1 << 22;                    er[3] = 32'h3F000000;
        for (int i = 0; i < 4; i++) begin
            drive_one(s[i], e[i], m[i], res, fl, lat);
            checks++;
            if (res !== er[i] || fl !== 4'b0000) begin
                failures++;
                $display("FAIL normalise_%0d: got %h/%b want %h/0000", i, res, fl, er[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [27:0] m[4];
        logic [31:0] er[4];
        logic [31:0] res; logic [3:0] fl; int lat;
        // tie with even LSB, tie with odd LSB, G&R, R only
        m[0] = mk(1'b0, 1'b1, 23'h0, 3'b100); er[0] = 32'h3F800000;
        m[1] = mk(1'b0, 1'b1, 23'h1, 3'b100); er[1] = 32'h3F800002;
        m[2] = mk(1'b0, 1'b1, 23'h0, 3'b110); er[2] = 32'h3F800001;
        m[3] = mk(1'b0, 1'b1, 23'h1, 3'b010); er[3] = 32'h3F800001;
        for (int i = 0; i < 4; i++) begin
            drive_one(1'b0, 8'd127, m[i], res, fl, lat);
            checks++;
            if (res !== er[i] || fl !== 4'b0010) begin
                failures++;
                $display("FAIL rounding_%0d: got %h/%b want %h/0010", i, res, fl, er[i]);
            end
        end
    endtask

    task automatic test_round_carry_overflow();
        logic [31:0] res; logic [3:0] fl; int lat;
        drive_one(1'b0, 8'd127, mk(1'b0, 1'b1, 23'h7FFFFF, 3'b100), res, fl, lat);
        checks++;
        if (res !== 32'h40000000 || fl !== 4'b0010) begin
            failures++; $display("FAIL round_carry: got %h/%b want 40000000/0010", res, fl);
        end
        drive_one(1'b0, 8'd254, mk(1'b0, 1'b1, 23'h0, 3'b000), res, fl, lat);
        checks++;
        if (res !== 32'h7F000000 || fl !== 4'b0000) begin
            failures++; $display("FAIL max_exp: got %h/%b want 7f000000/0000", res, fl);
        end
        drive_one(1'b0, 8'd254, mk(1'b1, 1'b0, 23'h0, 3'b000), res, fl, lat);
        checks++;
        if (res !== 32'h7F800000 || fl !== 4'b1010) begin
            failures++; $display("FAIL overflow_pos: got %h/%b want 7f800000/1010", res, fl);
        end
        drive_one(1'b1, 8'd254, mk(1'b0, 1'b1, 23'h7FFFFF, 3'b111), res, fl, lat);
        checks++;
        if (res !== 32'hFF800000 || fl !== 4'b1010) begin
            failures++; $display("FAIL overflow_neg: got %h/%b want ff800000/1010", res, fl);
        end
    endtask

    task automatic test_zero();
        logic [31:0] res; logic [3:0] fl; int lat;
        drive_one(1'b1, 8'd55, 28'h0, res, fl, lat);
        checks++;
        if (res !== 32'h00000000 || fl !== 4'b0001) begin
            failures++; $display("FAIL zero_input: got %h/%b want 00000000/0001", res, fl);
        end
    endtask

    task automatic test_underflow();
        logic [7:0]  e[3];
        logic [27:0] m[3];
        logic [31:0] er[3];
        logic [3:0]  ef[3];
        logic [31:0] res; logic [3:0] fl; int lat;
        // normalises to exactly exponent 1: normal in both builds
        e[0] = 8'd3; m[0] = 28'h1 << 24; er[0] = 32'h00800000; ef[0] = 4'b0000;
        e[1] = 8'd1; m[1] = 28'h1 << 25;
        e[2] = 8'd2; m[2] = 28'h1 << 24;
`ifdef FP_NORM_SUBNORMAL_EN
        er[1] = 32'h00400000; ef[1] = 4'b0000;
        er[2] = 32'h00400000; ef[2] = 4'b0000;
`else
        er[1] = 32'h00000000; ef[1] = 4'b0111;
        er[2] = 32'h00000000; ef[2] = 4'b0111;
`endif
        for (int i = 0; i < 3; i++) begin
            drive_one(1'b0, e[i], m[i], res, fl, lat);
            checks++;
            if (res !== er[i] || fl !== ef[i]) begin
                failures++;
                $display("FAIL underflow_%0d: got %h/%b want %h/%b", i, res, fl, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  e[4];
        logic [27:0] m[4];
        logic [31:0] er[4];
        logic [3:0]  ef[4];
        int sent, got, cyc, bad_stable;
        logic saw_not_ready;
        e[0] = 8'd127; m[0] = mk(1'b0, 1'b1, 23'h0, 3'b000); er[0] = 32'h3F800000; ef[0] = 4'b0000;
        e[1] = 8'd127; m[1] = mk(1'b1, 1'b0, 23'h0, 3'b000); er[1] = 32'h40000000; ef[1] = 4'b0000;
        e[2] = 8'd127; m[2] = 28'h1 << 25;                   er[2] = 32'h3F000000; ef[2] = 4'b0000;
        e[3] = 8'd127; m[3] = mk(1'b0, 1'b1, 23'h1, 3'b100); er[3] = 32'h3F800002; ef[3] = 4'b0010;
        sent = 0; got = 0; cyc = 0; bad_stable = 0; saw_not_ready = 1'b0;
        exp_q.delete();
        flag_q.delete();
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            #1;
            if (out_valid && !out_ready && exp_q.size() > 0) begin
                if (out_result !== exp_q[0]) bad_stable++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra_beat: got %h with nothing expected", out_result);
                end else begin
                    logic [31:0] xr; logic [3:0] xf;
                    xr = exp_q.pop_front();
                    xf = flag_q.pop_front();
                    if (out_result !== xr || out_flags !== xf) begin
                        failures++;
                        $display("FAIL b2b_beat_%0d: got %h/%b want %h/%b", got, out_result, out_flags, xr, xf);
                    end
                end
                got++;
            end
            if (sent < 4) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_exp   = e[sent];
                in_mant  = m[sent];
                if (in_ready) begin
                    exp_q.push_back(er[sent]);
                    flag_q.push_back(ef[sent]);
                    sent++;
                end else begin
                    saw_not_ready = 1'b1;
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_count: got %0d beats want 4, %0d left", got, exp_q.size());
        end
        checks++;
        if (!saw_not_ready) begin
            failures++; $display("FAIL b2b_in_ready_drop: got in_ready always 1 want a 0 while full");
        end
        checks++;
        if (bad_stable != 0) begin
            failures++; $display("FAIL b2b_stall_stable: got %0d changed cycles want 0", bad_stable);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic [3:0] fl; int lat;
        logic stale;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_exp    = 8'd127;
        in_mant   = mk(1'b0, 1'b1, 23'h0, 3'b000);
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = mk(1'b1, 1'b0, 23'h0, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL midreset_filled: got out_valid %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async: got valid %b result %h ready %b want 0/00000000/1",
                     out_valid, out_result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++; $display("FAIL midreset_stale: got out_valid 1 after reset want 0");
        end
        drive_one(1'b0, 8'd100, mk(1'b0, 1'b1, 23'h0, 3'b000), res, fl, lat);
        checks++;
        if (lat != 2 || res !== 32'h32000000 || fl !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_first: got lat %0d %h/%b want 2 32000000/0000", lat, res, fl);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_latency();
        test_normalise();
        test_rounding();
        test_round_carry_overflow();
        test_zero();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_norm_round_pipe.md
FP_NORM_ROUND_PIPE -- requirements
Module: fp_norm_round_pipe

Interface
REQ-001 SHALL have parameter EXP_W, 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, 23, stored fraction width; IN_W = MAN_W+5 is derived.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in_sign  input  1  result sign.
REQ-008 SHALL have port in_exp  input  EXP_W  biased exponent before normalisation.
REQ-009 SHALL have port in_mant  input  IN_W  magnitude: [IN_W-1] carry, [IN_W-2] hidden, [IN_W-3:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port out_result  output  1+EXP_W+MAN_W  packed {sign, exp, fraction}.
REQ-013 SHALL have port out_flags  output  4  {overflow, underflow, inexact, zero}.

Function
REQ-014 SHALL be a 2-stage valid/ready pipeline: S1 normalise, S2 round/pack; latency 2 cycles with out_ready high, throughput 1 beat/cycle.
REQ-015 SHALL transfer a beat only when valid and ready are both high; a stage loads when empty or its contents move downstream the same cycle.
REQ-016 SHALL drive in_ready = !s1_valid | s1_advance (combinational from out_ready); out_result/out_flags SHALL be stable while out_valid & !out_ready.
REQ-017 SHALL in S1, if carry set: shift right 1 (shifted-out bit ORed into sticky), exp+1; else left-shift by leading-zero count to place hidden bit at [IN_W-2], exp minus count.
REQ-018 SHALL compute exponents internally as signed EXP_W+2 bits; no wrap-around.
REQ-019 SHALL round to nearest-even: increment when G & (R | S | fraction LSB); inexact = G|R|S after normalisation.
REQ-020 SHALL on rounding carry-out (all-ones fraction +1) zero the fraction and increment exponent in S2.
REQ-021 SHALL on final exponent >= 2^EXP_W-1 output signed infinity (exp all ones, fraction 0), flags overflow|inexact.
REQ-022 SHALL on in_mant == 0 output +0 (sign 0, exp 0, fraction 0), flag zero only, irrespective of in_sign/in_exp.
REQ-023 SHALL on final exponent <= 0 apply the underflow rule of REQ-028/029.
REQ-024 SHALL preserve beat order; no beat dropped or duplicated under any out_ready pattern.

Reset
REQ-025 SHALL on rst_n low clear s1_valid, s2_valid, out_valid, out_result, out_flags to 0 asynchronously; in_ready reads 1 after reset.
REQ-026 SHALL discard in-flight beats on reset mid-operation; first beat after release emerges 2 cycles after acceptance.

Configuration
REQ-027 SHALL use macro FP_NORM_SUBNORMAL_EN to select underflow handling.
REQ-028 SHALL with FP_NORM_SUBNORMAL_EN defined: limit left shift so exponent stops at 1, then denormalise right to exp 0 producing a subnormal, rounded per REQ-019; underflow flagged only if result inexact.
REQ-029 SHALL without it: flush to signed zero, flags underflow|inexact|zero.

Structure
REQ-030 SHALL place in package fp_pkg: flag index constants, typedef fp_flags_t, rounding-mode enum (only RNE used), default EXP_W/MAN_W constants.
REQ-031 SHALL instantiate one sub-module fp_lzc (parametrised leading-zero counter, width IN_W-1, combinational).

Verification (EXP_W=8, MAN_W=23)
REQ-032 SHALL cover: exp=127, mant hidden only -> 0x3F800000, flags 0, out_valid 2 cycles after accept.
REQ-033 SHALL cover: exp=127, carry set only -> 0x40000000; exp=127, hidden at bit 22 (1 leading zero) -> 0x3F000000.
REQ-034 SHALL cover: fraction LSB=0, G=1,R=S=0 -> no increment, inexact; LSB=1 same GRS -> fraction+1.
REQ-035 SHALL cover: exp=127, fraction 0x7FFFFF, G=1 -> 0x40000000 inexact; exp=254, carry set -> 0x7F800000 overflow|inexact.
REQ-036 SHALL cover: 4 back-to-back beats, out_ready low 3 cycles -> in_ready drops once full, all 4 emerge in order; in_mant=0, in_sign=1 -> 0x00000000, zero flag.
REQ-037 SHALL cover: exp=1, hidden at bit 22 -> 0x00400000 with FP_NORM_SUBNORMAL_EN, 0x00000000 underflow|inexact|zero without.
